// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the RV32M operations
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Quotient returned for a divide by zero
    localparam logic [31:0] DIV_BY_ZERO_Q = '1;

    // rs1 is interpreted as signed for these operations
    function automatic logic rs1_is_signed(input muldiv_op_t f);
        return (f == MUL) || (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
    endfunction

    // rs2 is interpreted as signed for these operations
    function automatic logic rs2_is_signed(input muldiv_op_t f);
        return (f == MUL) || (f == MULH) || (f == DIV) || (f == REM);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand preparation: magnitudes, sign flags and divide corner-case detection.
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  muldiv_op_t        op,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_a,
    output logic              neg_b,
    output logic              is_div,
    output logic              div_by_zero,
    output logic              overflow
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    // Sign flags and magnitudes; the most negative value maps onto itself, which
    // is the correct unsigned magnitude
    always_comb begin
        neg_a = rs1_is_signed(op) & rs1_data[XLEN-1];
        neg_b = rs2_is_signed(op) & rs2_data[XLEN-1];
        mag_a = neg_a ? (~rs1_data + 1'b1) : rs1_data;
        mag_b = neg_b ? (~rs2_data + 1'b1) : rs2_data;
    end

    // Divide classification and the two results that bypass the iteration
    always_comb begin
        is_div      = op[2];
        div_by_zero = op[2] & (rs2_data == '0);
        overflow    = ((op == DIV) || (op == REM)) & (rs1_data == MIN_INT) & (rs2_data == '1);
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, with final sign fixup.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; accepting an op asserts stall in that cycle
// CALC  | one iteration per cycle, count runs XLEN-1 down to 0
// DONE  | done pulse, result/rd valid; stall released so pipeline advances
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        rd_address,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        out_rd_address
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t      state, next_state;
    muldiv_op_t         op_in, op_q;
    logic [CNT_W-1:0]   count;
    logic [2*XLEN-1:0]  acc;
    logic [XLEN-1:0]    operand_q;
    logic [4:0]         rd_q;
    logic               neg_a_q, neg_b_q, fast_q;

    logic [XLEN-1:0]    mag_a, mag_b;
    logic               neg_a, neg_b, is_div, div_by_zero, overflow;
    logic               accept;

    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;
    logic [XLEN:0]      rem_shift;
    logic               div_ge;
    logic [XLEN-1:0]    div_diff;
    logic [2*XLEN-1:0]  div_next;

    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quot, rem, sel;

    assign op_in  = muldiv_op_t'(op);
    assign accept = (state == IDLE) & start & ~flush;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .op          (op_in),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .neg_a       (neg_a),
        .neg_b       (neg_b),
        .is_div      (is_div),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake outputs; flush always returns to IDLE
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    next_state = (div_by_zero | overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (count == '0) next_state = DONE;
            end
            DONE: begin
                done       = ~flush;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // One iteration step: acc = {partial product, multiplier} for multiply,
    // {partial remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand_q : '0)};
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = rem_shift >= {1'b0, operand_q};
        div_diff  = rem_shift[XLEN-1:0] - operand_q;
        div_next  = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    end

    // Operand latch at acceptance and per-cycle iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= MUL;
            rd_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            fast_q    <= 1'b0;
            count     <= '0;
            acc       <= '0;
            operand_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                rd_q    <= rd_address;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
                fast_q  <= div_by_zero | overflow;
                count   <= CNT_W'(XLEN - 1);
                if (div_by_zero) begin
                    acc       <= {rs1_data, DIV_BY_ZERO_Q};
                    operand_q <= '0;
                end else if (overflow) begin
                    acc       <= {{XLEN{1'b0}}, MIN_INT};
                    operand_q <= '0;
                end else if (is_div) begin
                    acc       <= {{XLEN{1'b0}}, mag_a};
                    operand_q <= mag_b;
                end else begin
                    acc       <= {{XLEN{1'b0}}, mag_b};
                    operand_q <= mag_a;
                end
            end else if (state == CALC) begin
                acc   <= op_q[2] ? div_next : mul_next;
                count <= count - 1'b1;
            end
        end
    end

    // Sign fixup and result select; outputs held at zero outside the done pulse.
    // Fast-path results are stored final and bypass the fixup.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? (~acc + 1'b1) : acc;
        quot = (neg_a_q ^ neg_b_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem  = neg_a_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 sel = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: sel = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           sel = fast_q ? acc[XLEN-1:0] : quot;
            REM, REMU:           sel = fast_q ? acc[2*XLEN-1:XLEN] : rem;
            default:             sel = '0;
        endcase
        result         = done ? sel : '0;
        out_rd_address = done ? rd_q : '0;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized
// ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_address;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  out_rd_address;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rd_address     (rd_address),
        .flush          (flush),
        .stall          (stall),
        .done           (done),
        .result         (result),
        .out_rd_address (out_rd_address)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: RV32M semantics with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op at a negedge and observe for a fixed window; inputs are
    // scrambled after acceptance. With hold, start stays high until done.
    task automatic issue_and_wait(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input bit hold,
                                  output int lat, output logic [31:0] res, output logic [4:0] rdo,
                                  output int stall_cycles, output int pulses);
        lat = -1; res = '0; rdo = '0; stall_cycles = 0; pulses = 0;
        @(negedge clk);
        op = f; rs1_data = a; rs2_data = b; rd_address = rd; start = 1'b1;
        #1;
        if (stall) stall_cycles++;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_address = 5'($urandom);
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc; res = result; rdo = out_rd_address;
                end
                start = 1'b0;
            end
            if (stall) stall_cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_address = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (out_rd_address !== 5'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", out_rd_address); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul_basic();
        int lat, sc, pc;
        logic [31:0] res;
        logic [4:0] rdo;
        issue_and_wait(3'd0, 32'd7, 32'd6, 5'd5, 1'b0, lat, res, rdo, sc, pc);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_result got=%h exp=%h", res, 32'd42); end
        checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd got=%0d exp=5", rdo); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++; if (sc !== 33) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=33", sc); end
        checks++; if (pc !== 1) begin errors++; $display("FAIL mul_done_pulses got=%0d exp=1", pc); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [11] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] t_a   [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                    32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                                    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [11] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                    32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          t_lat [11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        int lat, sc, pc;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 11; i++) begin
            issue_and_wait(t_op[i], t_a[i], t_b[i], 5'(i + 1), 1'b0, lat, res, rdo, sc, pc);
            checks++;
            if (res !== t_exp[i]) begin
                errors++; $display("FAIL directed_result[%0d] op=%0d got=%h exp=%h", i, t_op[i], res, t_exp[i]);
            end
            checks++;
            if (lat !== t_lat[i] || pc !== 1) begin
                errors++; $display("FAIL directed_timing[%0d] latency=%0d pulses=%0d exp latency=%0d pulses=1", i, lat, pc, t_lat[i]);
            end
        end
    endtask

    task automatic test_flush();
        int lat, sc, pc, seen;
        logic [31:0] res;
        logic [4:0] rdo;
        @(negedge clk);
        op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_address = 5'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_busy_before got=%b exp=1", stall); end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_done_suppressed got=%0d pulses exp=0", seen); end
        // flush and start together: the op must not be accepted
        @(negedge clk);
        op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2; start = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_vs_start_stall got=%b exp=0", stall); end
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_vs_start_accepted got=%b exp=0", stall); end
        issue_and_wait(3'd0, 32'd3, 32'd3, 5'd11, 1'b0, lat, res, rdo, sc, pc);
        checks++; if (res !== 32'd9 || lat !== 33) begin
            errors++; $display("FAIL flush_then_mul got=%h latency=%0d exp=9 latency=33", res, lat);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat, sc, pc;
        logic [31:0] res;
        logic [4:0] rdo;
        @(negedge clk);
        op = 3'd3; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_address = 5'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3; reset = 1'b1; #1;
        checks++; if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0 || out_rd_address !== 5'h0) begin
            errors++; $display("FAIL async_reset_outputs stall=%b done=%b result=%h rd=%h exp all zero", stall, done, result, out_rd_address);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_reset_idle got stall=%b exp=0", stall); end
        issue_and_wait(3'd5, 32'd1000, 32'd7, 5'd12, 1'b1, lat, res, rdo, sc, pc);
        checks++; if (pc !== 1) begin errors++; $display("FAIL held_start_pulses got=%0d exp=1", pc); end
        checks++; if (res !== 32'd142 || rdo !== 5'd12) begin
            errors++; $display("FAIL held_start_result got=%h rd=%0d exp=%h rd=12", res, rdo, 32'd142);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        op = 3'd4; rs1_data = 32'd5; rs2_data = 32'd0; rd_address = 5'd3; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== exp_done[k]) begin
                errors++; $display("FAIL back_to_back_done[%0d] got=%b exp=%b", k, done, exp_done[k]);
            end
            if (k == 0) begin
                checks++;
                if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL back_to_back_result got=%h exp=ffffffff", result); end
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        int lat, sc, pc, exp_lat;
        logic [31:0] res, a, b, exp_res;
        logic [4:0] rdo, rd;
        logic [2:0] f;
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom);
            rd = 5'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'h1 << $urandom_range(0, 31);
                3: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
                4: a = 32'h8000_0000;
                default: ;
            endcase
            exp_res = ref_model(f, a, b);
            exp_lat = ref_latency(f, a, b);
            issue_and_wait(f, a, b, rd, 1'b0, lat, res, rdo, sc, pc);
            checks++;
            if (res !== exp_res) begin
                errors++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, res, exp_res);
            end
            checks++;
            if (lat !== exp_lat || pc !== 1 || rdo !== rd || sc !== exp_lat) begin
                errors++; $display("FAIL random_timing[%0d] op=%0d latency=%0d pulses=%0d rd=%0d stalls=%0d exp latency=%0d pulses=1 rd=%0d stalls=%0d",
                                   i, f, lat, pc, rdo, sc, exp_lat, rd, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
